hub75_bcm_seq: RTL

// - Per-row bit-plane sequencer for the HUB75 panel driver. It is the parametrised

---
 rtl/hub75_bcm_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/hub75_bcm_seq.sv
// Per-row HUB75 bit-plane sequencer: walks a captured plane window, issuing shift/blank
// pulses and the row address / latch enable timing for each plane.
module hub75_bcm_seq #(
  parameter int N_ROWS       = 32,
  parameter int N_PLANES     = 8,
  parameter int TIMER_W      = 8,
  parameter int LOG_N_ROWS   = $clog2(N_ROWS),
  parameter int LOG_N_PLANES = $clog2(N_PLANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [LOG_N_ROWS-1:0]   hub75_addr,
  output logic                    hub75_le,
  output logic [N_PLANES-1:0]     shift_plane,
  output logic                    shift_go,
  input  logic                    shift_rdy,
  output logic [N_PLANES-1:0]     blank_plane,
  output logic                    blank_go,
  input  logic                    blank_rdy,
  input  logic [LOG_N_ROWS-1:0]   ctrl_row,
  input  logic                    ctrl_go,
  output logic                    ctrl_rdy,
  output logic                    ctrl_done,
  input  logic [LOG_N_PLANES-1:0] cfg_plane_lo,
  input  logic [LOG_N_PLANES-1:0] cfg_plane_hi,
  input  logic                    cfg_msb_first,
  input  logic [TIMER_W-1:0]      cfg_pre_latch_len,
  input  logic [TIMER_W-1:0]      cfg_latch_len,
  input  logic [TIMER_W-1:0]      cfg_post_latch_len,
  output logic [LOG_N_PLANES-1:0] stat_plane
);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_WAIT, S_PRE, S_LATCH, S_POST, S_BLANK
  } state_t;

  state_t state, state_nxt;

  logic [LOG_N_ROWS-1:0]   row_q;
  logic [LOG_N_PLANES-1:0] plane_q, last_q;
  logic                    msb_q;
  logic [TIMER_W-1:0]      pre_q, latch_q, post_q;
  logic [TIMER_W:0]        timer_q;
  logic                    le_q;
  logic [LOG_N_ROWS-1:0]   addr_q;

  logic [LOG_N_PLANES-1:0] lo_c, hi_c, first_c, last_c;
  logic                    accept, timer_zero, last_plane;

  function automatic logic [LOG_N_PLANES-1:0] clamp_plane(input logic [LOG_N_PLANES-1:0] v);
    if (32'(v) > N_PLANES - 1) return LOG_N_PLANES'(N_PLANES - 1);
    return v;
  endfunction

  // An inverted window degenerates to the single plane lo.
  always_comb begin
    lo_c    = clamp_plane(cfg_plane_lo);
    hi_c    = clamp_plane(cfg_plane_hi);
    first_c = lo_c;
    last_c  = hi_c;
    if (lo_c > hi_c) begin
      first_c = lo_c;
      last_c  = lo_c;
    end else if (cfg_msb_first) begin
      first_c = hi_c;
      last_c  = lo_c;
    end
  end

  assign accept     = ctrl_go && (state == S_IDLE);
  assign timer_zero = (timer_q == '0);
  assign last_plane = (plane_q == last_q);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_go  = 1'b0;
    blank_go  = 1'b0;
    ctrl_done = 1'b0;
    case (state)
      S_IDLE:  if (ctrl_go) state_nxt = S_SHIFT;
      S_SHIFT: begin
        shift_go  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT:  if (shift_rdy && blank_rdy) state_nxt = S_PRE;
      S_PRE:   if (timer_zero) state_nxt = S_LATCH;
      S_LATCH: if (timer_zero) state_nxt = S_POST;
      S_POST:  if (timer_zero) state_nxt = S_BLANK;
      S_BLANK: begin
        blank_go = 1'b1;
        if (last_plane) begin
          state_nxt = S_IDLE;
          ctrl_done = 1'b1;
        end else begin
          state_nxt = S_SHIFT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Each latch phase loads L on entry and exits when the count reaches zero: L+1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else if (state == S_WAIT && state_nxt == S_PRE) begin
      timer_q <= {1'b0, pre_q};
    end else if (state == S_PRE && timer_zero) begin
      timer_q <= {1'b0, latch_q};
    end else if (state == S_LATCH && timer_zero) begin
      timer_q <= {1'b0, post_q};
    end else if (!timer_zero) begin
      timer_q <= timer_q - (TIMER_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      plane_q <= '0;
      last_q  <= '0;
      msb_q   <= 1'b0;
      pre_q   <= '0;
      latch_q <= '0;
      post_q  <= '0;
      le_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      if (accept) begin
        row_q   <= ctrl_row;
        plane_q <= first_c;
        last_q  <= last_c;
        msb_q   <= cfg_msb_first && (lo_c <= hi_c);
        pre_q   <= cfg_pre_latch_len;
        latch_q <= cfg_latch_len;
        post_q  <= cfg_post_latch_len;
      end else if (state == S_BLANK && !last_plane) begin
        plane_q <= msb_q ? plane_q - LOG_N_PLANES'(1) : plane_q + LOG_N_PLANES'(1);
      end
      le_q <= (state == S_LATCH);
      // First DO_LATCH cycle: address updates on the same edge the latch enable rises.
      if (state == S_LATCH && !le_q) addr_q <= row_q;
    end
  end

  assign hub75_le    = le_q;
  assign hub75_addr  = addr_q;
  assign ctrl_rdy    = (state == S_IDLE);
  assign stat_plane  = (state == S_IDLE) ? '0 : plane_q;
  assign shift_plane = (state == S_IDLE) ? '0 : ({{(N_PLANES-1){1'b0}}, 1'b1} << plane_q);
  assign blank_plane = shift_plane;

endmodule
